// File: rtl/vector_pack_seq.sv
// vector_pack_seq
//   Collects six 5-bit fields (a..f) from a serial producer, packs them into
//   the 32-bit word {a, b, c, d, e, f, PAD} and streams that word to a
//   byte-wide consumer MSB byte first (w, x, y, z).
//
// Ports
//   clk, rst_n     clock / asynchronous active-low reset
//   flush          synchronous abort of the frame in progress
//   in_valid       producer offers in_data
//   in_data[4:0]   field value, order a..f
//   in_ready       registered; high while collecting fields
//   out_valid      registered; out_data holds a byte of the packed word
//   out_data[7:0]  current byte (w = word[31:24] ... z = word[7:0])
//   out_last       high together with byte z
//   out_ready      consumer accepts the byte this cycle
//   frame_count    completed frames, wraps modulo 256
module vector_pack_seq #(
    parameter logic [1:0] PAD = 2'b11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    input  logic [4:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic [7:0] frame_count
);

    typedef enum logic {COLLECT, EMIT} state_t;

    localparam int NUM_FIELDS = 6;
    localparam int FIELD_W    = 5;

    state_t                                 state;
    logic [2:0]                             fcnt;
    logic [1:0]                             bcnt;
    // fields[0] = a ... fields[5] = f
    logic [NUM_FIELDS-1:0][FIELD_W-1:0]     fields;

    logic        in_hs;
    logic        out_hs;
    logic [31:0] word_cur;   // word built from the stored fields
    logic [31:0] word_fill;  // word as it will be once the arriving field lands in slot f

    // Byte idx of a word, MSB byte first.
    function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    // in_ready/out_valid are themselves state-qualified registers, so the
    // handshakes need no extra decode.
    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

    assign word_cur  = {fields[0], fields[1], fields[2], fields[3], fields[4], fields[5], PAD};
    assign word_fill = {fields[0], fields[1], fields[2], fields[3], fields[4], in_data,   PAD};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COLLECT;
            fcnt        <= '0;
            bcnt        <= '0;
            fields      <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            frame_count <= '0;
        end else if (flush) begin
            // Abort wins over any handshake in the same cycle.
            state     <= COLLECT;
            fcnt      <= '0;
            bcnt      <= '0;
            fields    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    // Also raises in_ready on the first edge after reset.
                    in_ready <= 1'b1;
                    if (in_hs) begin
                        fields[fcnt] <= in_data;
                        if (fcnt == 3'(NUM_FIELDS - 1)) begin
                            // Last field: present byte w on the very next cycle,
                            // built from the incoming field directly.
                            fcnt      <= '0;
                            state     <= EMIT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= pick(word_fill, 2'd0);
                            out_last  <= 1'b0;
                        end else begin
                            fcnt <= fcnt + 3'd1;
                        end
                    end
                end
                EMIT: begin
                    if (out_hs) begin
                        if (bcnt == 2'd3) begin
                            bcnt        <= '0;
                            state       <= COLLECT;
                            frame_count <= frame_count + 8'd1;
                            in_ready    <= 1'b1;
                            out_valid   <= 1'b0;
                            out_data    <= '0;
                            out_last    <= 1'b0;
                        end else begin
                            bcnt     <= bcnt + 2'd1;
                            out_data <= pick(word_cur, bcnt + 2'd1);
                            out_last <= (bcnt == 2'd2);
                        end
                    end
                    // Without a handshake out_data/out_last hold.
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_pack_seq.sv
// Bench for vector_pack_seq: directed stimulus, a queue-based reference of
// the byte stream checked every cycle at the falling edge, plus literal
// expectations for each directed scenario.
module tb_vector_pack_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [4:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic [7:0] frame_count;

    vector_pack_seq #(.PAD(2'b11)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [4:0] part[$];    // fields accepted in the current frame
    logic [8:0] expq[$];    // {last, byte} still owed to the consumer
    logic [7:0] seen[$];    // bytes actually transferred (for literal checks)
    int         fc_m = 0;
    bit         armed = 0;  // an edge with rst_n high has occurred
    bit         prev_hold = 0;
    logic [7:0] prev_data;
    logic       prev_last;

    always @(posedge clk) armed = rst_n;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_frame_count", frame_count, 0);
            part.delete(); expq.delete(); fc_m = 0; prev_hold = 0;
        end else begin
            chk("in_ready", in_ready, armed && expq.size() == 0);
            chk("out_valid", out_valid, expq.size() != 0);
            chk("frame_count", frame_count, fc_m[7:0]);
            if (out_valid && expq.size() != 0) begin
                chk("out_data", out_data, expq[0][7:0]);
                chk("out_last", out_last, expq[0][8]);
            end
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            prev_hold = out_valid && !out_ready && !flush;
            prev_data = out_data;
            prev_last = out_last;
            if (flush) begin
                part.delete(); expq.delete();
            end else begin
                if (in_valid && in_ready) begin
                    part.push_back(in_data);
                    if (part.size() == 6) begin
                        logic [31:0] w;
                        w = 0;
                        foreach (part[i]) w = (w << 5) | 32'(part[i]);
                        w = (w << 2) | 32'h3;
                        for (int k = 0; k < 4; k++)
                            expq.push_back({k == 3, w[31 - 8*k -: 8]});
                        part.delete();
                    end
                end
                if (out_valid && out_ready && expq.size() != 0) begin
                    logic [8:0] e;
                    e = expq.pop_front();
                    seen.push_back(out_data);
                    if (e[8]) fc_m = (fc_m + 1) % 256;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_field(input logic [4:0] v, input bit gap);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_data  = v;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", 1, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (gap) begin
            in_data = ~v;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [4:0] f0, f1, f2, f3, f4, f5, input bit gap);
        send_field(f0, gap); send_field(f1, gap); send_field(f2, gap);
        send_field(f3, gap); send_field(f4, gap); send_field(f5, gap);
    endtask

    task automatic wait_seen(input int n);
        for (int i = 0; i < 200 && seen.size() < n; i++) @(posedge clk);
        if (seen.size() < n) chk("wait_seen_timeout", seen.size(), n);
        #1;
    endtask

    task automatic check_bytes(input string nm, input logic [7:0] b0, b1, b2, b3);
        chk({nm, "_count"}, seen.size(), 4);
        if (seen.size() == 4) begin
            chk({nm, "_w"}, seen[0], b0);
            chk({nm, "_x"}, seen[1], b1);
            chk({nm, "_y"}, seen[2], b2);
            chk({nm, "_z"}, seen[3], b3);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 5'h1F; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b0;
        chk("ready_before_edge", in_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_edge", in_ready, 1);

        // Basic frame, back-to-back, no backpressure.
        seen.delete();
        send_frame(5'h1F, 5'h00, 5'h15, 5'h0A, 5'h11, 5'h03, 0);
        wait_seen(4);
        check_bytes("basic", 8'hF8, 8'h2A, 8'hA8, 8'h8F);
        @(posedge clk); #1;
        chk("basic_fc", frame_count, 1);

        // Backpressure: 2A held for 3 cycles.
        seen.delete();
        out_ready = 1'b0;
        send_frame(5'h1F, 5'h00, 5'h15, 5'h0A, 5'h11, 5'h03, 0);
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        @(posedge clk); #1 out_ready = 1'b1;     // accept w
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_held_data", out_data, 8'h2A);
        chk("bp_held_last", out_last, 0);
        chk("bp_held_count", seen.size(), 1);
        out_ready = 1'b1;
        wait_seen(4);
        check_bytes("bp", 8'hF8, 8'h2A, 8'hA8, 8'h8F);
        @(posedge clk); #1;
        chk("bp_fc", frame_count, 2);

        // Producer gaps between fields.
        seen.delete();
        send_frame(5'h1F, 5'h00, 5'h15, 5'h0A, 5'h11, 5'h03, 1);
        wait_seen(4);
        check_bytes("gaps", 8'hF8, 8'h2A, 8'hA8, 8'h8F);

        // Flush after 3 fields, then a full frame.
        repeat (2) @(posedge clk); #1;
        seen.delete();
        send_field(5'h07, 0); send_field(5'h08, 0); send_field(5'h09, 0);
        flush = 1'b1; in_valid = 1'b1; in_data = 5'h1F;
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        send_frame(5'h1F, 5'h00, 5'h15, 5'h0A, 5'h11, 5'h03, 0);
        wait_seen(4);
        check_bytes("flush_collect", 8'hF8, 8'h2A, 8'hA8, 8'h8F);
        @(posedge clk); #1;
        chk("flush_collect_fc", frame_count, 4);

        // Flush during EMIT while byte x is presented.
        seen.delete();
        out_ready = 1'b0;
        send_frame(5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 0);
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 flush = 1'b1;          // x handshake discarded
        @(posedge clk); #1 flush = 1'b0;
        repeat (5) @(posedge clk); #1;
        chk("flush_emit_bytes", seen.size(), 1);
        chk("flush_emit_valid", out_valid, 0);
        chk("flush_emit_fc", frame_count, 4);

        // Reset mid-frame; also zeroes frame_count before the wrap run.
        send_field(5'h1F, 0); send_field(5'h1F, 0);
        #1 rst_n = 1'b0;
        #1 chk("async_rst_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_fc", frame_count, 0);

        // Wrap: 256 zero frames.
        for (int f = 0; f < 256; f++) begin
            seen.delete();
            send_frame(5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0);
            wait_seen(4);
            if (f == 0 || f == 255) check_bytes("wrap", 8'h00, 8'h00, 8'h00, 8'h03);
            if (f == 254) begin
                @(posedge clk); #1;
                chk("wrap_fc_255", frame_count, 255);
            end
        end
        @(posedge clk); #1;
        chk("wrap_fc_0", frame_count, 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
